bf_run_controller: RTL and testbench

Sequencer that owns the BF core's lifecycle: it streams a program from a host byte interface into program memory, zero-fills data memory, releases the core from reset, then watches for halt or a cycle-limit timeout. It sits between the host and the BF core plus its two memories, holding the core in reset whenever it is not in the Run phase.

---
 rtl/bf_run_controller.sv | 156 +++++++++++++++
 tb/tb_bf_run_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_run_controller.sv
// BF core lifecycle sequencer: program load, data clear, run, halt/timeout.
// Holds the core in reset outside the Run phase.
module bf_run_controller #(
   parameter int PROG_ADDR_SIZE = 16,
   parameter int DATA_ADDR_SIZE = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      abort,
   input  logic [7:0]                load_data,
   input  logic                      load_valid,
   output logic                      load_ready,
   output logic [PROG_ADDR_SIZE-1:0] prog_addr,
   output logic [7:0]                prog_wdata,
   output logic                      prog_we,
   output logic [DATA_ADDR_SIZE-1:0] data_addr,
   output logic                      data_we,
   output logic                      core_reset,
   input  logic                      core_halted,
   input  logic [31:0]               run_limit,
   output logic [31:0]               cycle_count,
   output logic                      busy,
   output logic                      done,
   output logic                      timeout,
   output logic                      overflow
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CLEAR,
      S_RUN,
      S_DONE
   } state_t;

   state_t state, state_next;

   logic [PROG_ADDR_SIZE-1:0] prog_cnt;
   logic [DATA_ADDR_SIZE-1:0] data_cnt;

   logic prog_full;
   logic byte_zero;
   logic clear_last;
   logic limit_hit;

   assign prog_full  = (prog_cnt == '1);
   assign byte_zero  = (load_data == 8'h00);
   assign clear_last = (data_cnt == '1);
   assign limit_hit  = (run_limit != 32'd0) && (cycle_count == run_limit);

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: if (start) state_next = S_LOAD;
            S_LOAD: begin
               if (load_valid && (byte_zero || prog_full))
                  state_next = S_CLEAR;
            end
            S_CLEAR: if (clear_last) state_next = S_RUN;
            S_RUN: begin
               if (core_halted || limit_hit) state_next = S_DONE;
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   // Counters and sticky flags; abort leaves them untouched
   always_ff @(posedge clock) begin
      if (reset) begin
         prog_cnt    <= '0;
         data_cnt    <= '0;
         cycle_count <= '0;
         timeout     <= 1'b0;
         overflow    <= 1'b0;
      end else if (!abort) begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  prog_cnt <= '0;
                  timeout  <= 1'b0;
                  overflow <= 1'b0;
               end
            end
            S_LOAD: begin
               if (load_valid) begin
                  if (byte_zero) begin
                     data_cnt <= '0;
                  end else if (prog_full) begin
                     data_cnt <= '0;
                     overflow <= 1'b1;
                  end else begin
                     prog_cnt <= prog_cnt + 1'b1;
                  end
               end
            end
            S_CLEAR: begin
               data_cnt <= data_cnt + 1'b1;
               if (clear_last) cycle_count <= '0;
            end
            S_RUN: begin
               if (!core_halted) begin
                  if (limit_hit)
                     timeout <= 1'b1;
                  else if (cycle_count != '1)
                     cycle_count <= cycle_count + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      load_ready = 1'b0;
      prog_we    = 1'b0;
      prog_addr  = '0;
      prog_wdata = 8'h00;
      data_we    = 1'b0;
      data_addr  = '0;
      core_reset = 1'b1;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         S_LOAD: begin
            busy       = 1'b1;
            load_ready = 1'b1;
            prog_we    = load_valid;
            prog_addr  = prog_cnt;
            // Last slot always gets a terminator
            prog_wdata = prog_full ? 8'h00 : load_data;
         end
         S_CLEAR: begin
            busy      = 1'b1;
            data_we   = 1'b1;
            data_addr = data_cnt;
         end
         S_RUN: begin
            busy       = 1'b1;
            core_reset = 1'b0;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bf_run_controller.sv
// Directed bench for bf_run_controller with tiny memories
// (3-bit program address, 4-bit data address).
module tb_bf_run_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [7:0]  load_data;
   logic        load_valid;
   logic        load_ready;
   logic [2:0]  prog_addr;
   logic [7:0]  prog_wdata;
   logic        prog_we;
   logic [3:0]  data_addr;
   logic        data_we;
   logic        core_reset;
   logic        core_halted;
   logic [31:0] run_limit;
   logic [31:0] cycle_count;
   logic        busy;
   logic        done;
   logic        timeout;
   logic        overflow;

   bf_run_controller #(
      .PROG_ADDR_SIZE(3),
      .DATA_ADDR_SIZE(4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .load_data   (load_data),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .prog_addr   (prog_addr),
      .prog_wdata  (prog_wdata),
      .prog_we     (prog_we),
      .data_addr   (data_addr),
      .data_we     (data_we),
      .core_reset  (core_reset),
      .core_halted (core_halted),
      .run_limit   (run_limit),
      .cycle_count (cycle_count),
      .busy        (busy),
      .done        (done),
      .timeout     (timeout),
      .overflow    (overflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          seg;
      string       name;
      logic        rst;
      logic        st;
      logic        ab;
      logic        lv;
      logic [7:0]  ld;
      logic [17:0] exp;
   } vec_t;

   vec_t tv[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic void check(string name, logic [63:0] act,
                                 logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // {load_ready,prog_we,prog_addr,prog_wdata,data_we,core_reset,busy,done,overflow}
   function automatic logic [17:0] e_idle(logic ovf);
      return {1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, ovf};
   endfunction

   function automatic logic [17:0] e_done(logic ovf);
      return {1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, ovf};
   endfunction

   function automatic logic [17:0] e_clear(logic ovf);
      return {1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, ovf};
   endfunction

   function automatic logic [17:0] e_load(logic [2:0] pa, logic [7:0] pwd,
                                          logic pwe);
      return {1'b1, pwe, pa, pwd, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   endfunction

   function automatic vec_t mk(int seg, string nm, logic rst, logic st,
                               logic ab, logic lv, logic [7:0] ld,
                               logic [17:0] exp);
      vec_t v;
      v.seg  = seg;
      v.name = nm;
      v.rst  = rst;
      v.st   = st;
      v.ab   = ab;
      v.lv   = lv;
      v.ld   = ld;
      v.exp  = exp;
      return v;
   endfunction

   task automatic run_seg(int s);
      foreach (tv[i]) begin
         if (tv[i].seg == s) begin
            @(negedge clock);
            reset       = tv[i].rst;
            start       = tv[i].st;
            abort       = tv[i].ab;
            load_valid  = tv[i].lv;
            load_data   = tv[i].ld;
            core_halted = 1'b0;
            #1;
            check(tv[i].name,
                  {load_ready, prog_we, prog_addr, prog_wdata, data_we,
                   core_reset, busy, done, overflow},
                  tv[i].exp);
         end
      end
   endtask

   task automatic do_clear(int lo, int hi);
      for (int i = lo; i <= hi; i++) begin
         @(negedge clock);
         start      = 1'b0;
         abort      = 1'b0;
         load_valid = 1'b0;
         #1;
         check("clear", {data_we, data_addr, core_reset, busy,
                         load_ready, prog_we},
               {1'b1, i[3:0], 1'b1, 1'b1, 1'b0, 1'b0});
      end
   endtask

   // halt_at < 0: core never halts
   task automatic run_core(int halt_at, int limit, logic exp_to,
                           logic exp_ovf, logic [31:0] exp_cnt);
      bit stopped = 0;
      run_limit = limit;
      for (int k = 0; k < 200 && !stopped; k++) begin
         @(negedge clock);
         core_halted = (halt_at >= 0) && (k >= halt_at);
         #1;
         check("run", {core_reset, busy, done, cycle_count},
               {1'b0, 1'b1, 1'b0, k[31:0]});
         if (core_halted || (limit != 0 && k == limit)) stopped = 1;
      end
      if (!stopped) check("run_bound", 64'd0, 64'd1);
      @(negedge clock);
      core_halted = 1'b0;
      start       = 1'b0;
      #1;
      check("run_end", {done, busy, core_reset, timeout, overflow,
                        cycle_count},
            {1'b1, 1'b0, 1'b1, exp_to, exp_ovf, exp_cnt});
   endtask

   initial begin
      logic [7:0] p5[4];
      p5 = '{8'h2B, 8'h5B, 8'h5D, 8'h00};

      // "+.\0" from reset
      tv.push_back(mk(1, "reset",      1, 0, 0, 0, 8'h00, e_idle(0)));
      tv.push_back(mk(1, "idle_start", 0, 1, 0, 0, 8'h00, e_idle(0)));
      tv.push_back(mk(1, "ld_plus",    0, 0, 0, 1, 8'h2B, e_load(0, 8'h2B, 1)));
      tv.push_back(mk(1, "ld_dot",     0, 0, 0, 1, 8'h2E, e_load(1, 8'h2E, 1)));
      tv.push_back(mk(1, "ld_nul",     0, 0, 0, 1, 8'h00, e_load(2, 8'h00, 1)));

      // overflow: 10 bytes of '+' into 8-entry memory
      tv.push_back(mk(2, "done_start", 0, 1, 0, 0, 8'h00, e_done(0)));
      for (int i = 0; i < 8; i++)
         tv.push_back(mk(2, "ovf_ld", 0, 0, 0, 1, 8'h2B,
                         e_load(i[2:0], (i == 7) ? 8'h00 : 8'h2B, 1)));
      tv.push_back(mk(2, "ovf_extra", 0, 0, 0, 1, 8'h2B, e_clear(1)));
      tv.push_back(mk(2, "ovf_extra", 0, 0, 0, 1, 8'h2B, e_clear(1)));

      // overflowing load again, aborted during Clear
      tv.push_back(mk(3, "done_start2", 0, 1, 0, 0, 8'h00, e_done(1)));
      for (int i = 0; i < 8; i++)
         tv.push_back(mk(3, "ovf_ld2", 0, 0, 0, 1, 8'h2B,
                         e_load(i[2:0], (i == 7) ? 8'h00 : 8'h2B, 1)));

      // "\0" after abort
      tv.push_back(mk(4, "abort_start", 0, 1, 0, 0, 8'h00, e_idle(1)));
      tv.push_back(mk(4, "nul_only",    0, 0, 0, 1, 8'h00, e_load(0, 8'h00, 1)));

      // "+[]\0" infinite loop
      tv.push_back(mk(5, "done_start3", 0, 1, 0, 0, 8'h00, e_done(0)));
      for (int i = 0; i < 4; i++)
         tv.push_back(mk(5, "loop_ld", 0, 0, 0, 1, p5[i],
                         e_load(i[2:0], p5[i], 1)));

      // "++\0", halt and limit in the same cycle
      tv.push_back(mk(6, "done_start4", 0, 1, 0, 0, 8'h00, e_done(0)));
      tv.push_back(mk(6, "pp_ld0", 0, 0, 0, 1, 8'h2B, e_load(0, 8'h2B, 1)));
      tv.push_back(mk(6, "pp_ld1", 0, 0, 0, 1, 8'h2B, e_load(1, 8'h2B, 1)));
      tv.push_back(mk(6, "pp_ld2", 0, 0, 0, 1, 8'h00, e_load(2, 8'h00, 1)));

      // gapped load, then reset mid-Load
      tv.push_back(mk(7, "done_start5", 0, 1, 0, 0, 8'h00, e_done(0)));
      tv.push_back(mk(7, "gap_v0",  0, 0, 0, 1, 8'h2B, e_load(0, 8'h2B, 1)));
      tv.push_back(mk(7, "gap_i0",  0, 0, 0, 0, 8'h55, e_load(1, 8'h55, 0)));
      tv.push_back(mk(7, "gap_i1",  0, 0, 0, 0, 8'h55, e_load(1, 8'h55, 0)));
      tv.push_back(mk(7, "gap_v1",  0, 0, 0, 1, 8'h2D, e_load(1, 8'h2D, 1)));
      tv.push_back(mk(7, "gap_i2",  0, 0, 0, 0, 8'h55, e_load(2, 8'h55, 0)));
      tv.push_back(mk(7, "gap_rst", 1, 0, 0, 0, 8'h55, e_load(2, 8'h55, 0)));
      tv.push_back(mk(7, "post_rst", 0, 0, 0, 0, 8'h55, e_idle(0)));

      reset       = 1'b1;
      start       = 1'b0;
      abort       = 1'b0;
      load_valid  = 1'b0;
      load_data   = 8'h00;
      core_halted = 1'b0;
      run_limit   = 32'd0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_state", {cycle_count, timeout, overflow, data_addr,
                            prog_addr, core_reset},
            {32'd0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b1});

      run_seg(1);
      do_clear(0, 15);
      run_core(3, 0, 1'b0, 1'b0, 32'd3);

      run_seg(2);
      do_clear(2, 15);
      run_core(2, 0, 1'b0, 1'b1, 32'd2);

      run_seg(3);
      do_clear(0, 4);
      @(negedge clock);
      abort = 1'b1;
      #1;
      check("abort_cycle", {data_we, data_addr}, {1'b1, 4'd5});
      @(negedge clock);
      abort = 1'b0;
      #1;
      check("after_abort", {data_we, core_reset, busy, done, overflow,
                            cycle_count},
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd2});

      run_seg(4);
      do_clear(0, 15);
      run_core(1, 0, 1'b0, 1'b0, 32'd1);

      run_seg(5);
      do_clear(0, 15);
      run_core(-1, 50, 1'b1, 1'b0, 32'd50);

      run_seg(6);
      do_clear(0, 15);
      run_core(3, 3, 1'b0, 1'b0, 32'd3);

      run_seg(7);
      check("post_rst_regs", {cycle_count, timeout, data_we, data_addr},
            {32'd0, 1'b0, 1'b0, 4'd0});

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
